// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution unit: issue packet, CDB row,
// branch function encoding and the internal FIFO entry.
package branch_resolve_pkg;

   localparam int XLEN   = 32;
   localparam int ROB_W  = 6;
   localparam int PREG_W = 7;

   typedef enum logic [2:0] {
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
   } BR_FUNC;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   rs2_val;
      logic [XLEN-1:0]   imm;
      BR_FUNC            func;
      logic              pred_taken;
      logic [XLEN-1:0]   pred_target;
      logic [ROB_W-1:0]  rob_id;
      logic [PREG_W-1:0] phys_reg;
   } BR_ISSUE;

   typedef struct packed {
      logic              valid;
      logic [ROB_W-1:0]  rob_id;
      logic [PREG_W-1:0] phys_reg;
      logic              branch_mispredict;
      logic [XLEN-1:0]   branch_target;
   } CDB_ROW;

   typedef enum logic {ST_RUN, ST_HOLD} br_state_e;

   // Resolved result as held in the FIFO; target is the actual next pc.
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic              taken;
      logic [XLEN-1:0]   target;
      logic              mispredict;
      logic [ROB_W-1:0]  rob_id;
      logic [PREG_W-1:0] phys_reg;
   } br_entry_t;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// br_cond_eval: purely combinational branch condition and next-pc evaluation.
// Compares the actual next pc against the predicted next pc.
module br_cond_eval
   import branch_resolve_pkg::*;
(
   input  BR_ISSUE         pkt,
   output logic            taken,
   output logic [XLEN-1:0] actual_next,
   output logic            mispredict
);

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] pred_next;

   assign seq_pc   = pkt.pc + XLEN'(4);
   assign jalr_sum = pkt.rs1_val + pkt.imm;

   // Decode taken condition and jump target per function
   always_comb begin
      taken  = 1'b0;
      br_tgt = pkt.pc + pkt.imm;
      case (pkt.func)
         BR_BEQ:  taken = (pkt.rs1_val == pkt.rs2_val);
         BR_BNE:  taken = (pkt.rs1_val != pkt.rs2_val);
         BR_BLT:  taken = ($signed(pkt.rs1_val) <  $signed(pkt.rs2_val));
         BR_BGE:  taken = ($signed(pkt.rs1_val) >= $signed(pkt.rs2_val));
         BR_BLTU: taken = (pkt.rs1_val <  pkt.rs2_val);
         BR_BGEU: taken = (pkt.rs1_val >= pkt.rs2_val);
         BR_JAL:  taken = 1'b1;
         BR_JALR: begin
            taken  = 1'b1;
            br_tgt = {jalr_sum[XLEN-1:1], 1'b0};
         end
         default: taken = 1'b0;
      endcase
   end

   assign actual_next = taken ? br_tgt : seq_pc;
   assign pred_next   = pkt.pred_taken ? pkt.pred_target : seq_pc;
   assign mispredict  = (actual_next != pred_next);

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: evaluates branch packets, queues results in a 2-entry
// FIFO toward the CDB and trains the predictor on grant. After a mispredict
// is queued, issue is blocked (HOLD) until that entry is granted.
// Optional: define BRANCH_RESOLVE_STATS_EN to add stat_resolved/stat_mispred.
module branch_resolve
   import branch_resolve_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            issue_valid,
   input  BR_ISSUE         issue_pkt,
   output logic            issue_ready,
   input  logic            flush,
   output logic            cdb_req,
   input  logic            cdb_grant,
   output CDB_ROW          cdb_row,
   output logic            bp_upd_valid,
   output logic [XLEN-1:0] bp_upd_pc,
   output logic            bp_upd_taken,
   output logic [XLEN-1:0] bp_upd_target
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_resolved,
   output logic [31:0]     stat_mispred
`endif
);

   localparam int DEPTH = 2;

   br_entry_t fifo_q [DEPTH];
   logic      wr_ptr, rd_ptr;
   logic [1:0] count;
   br_state_e state_q, state_d;

   logic      ev_taken, ev_mis;
   logic [XLEN-1:0] ev_next;
   br_entry_t new_ent, head;
   logic      push, pop, full;

   br_cond_eval u_eval (
      .pkt         (issue_pkt),
      .taken       (ev_taken),
      .actual_next (ev_next),
      .mispredict  (ev_mis)
   );

   assign new_ent = '{pc: issue_pkt.pc, taken: ev_taken, target: ev_next,
                      mispredict: ev_mis, rob_id: issue_pkt.rob_id,
                      phys_reg: issue_pkt.phys_reg};

   assign head    = fifo_q[rd_ptr];
   assign full    = (count == 2'd2);
   assign cdb_req = (count != 2'd0);
   assign push    = issue_valid && issue_ready;
   // Grant without a request is ignored; flush suppresses the pop.
   assign pop     = cdb_req && cdb_grant && !flush;

   // FIFO storage and pointers; flush empties it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= new_ent;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // FSM next state: only one mispredict can be in flight, so the
   // granted mispredicting head is the one that caused HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (push && ev_mis)       state_d = ST_HOLD;
         ST_HOLD: if (pop && head.mispredict) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
      if (flush) state_d = ST_RUN;
   end

   // FSM output: accept only in RUN with space and no flush
   always_comb begin
      issue_ready = reset && !full && (state_q == ST_RUN) && !flush;
   end

   // CDB row: head entry while non-empty, all-zero otherwise
   always_comb begin
      cdb_row = '0;
      if (cdb_req) begin
         cdb_row.valid             = 1'b1;
         cdb_row.rob_id            = head.rob_id;
         cdb_row.phys_reg          = head.phys_reg;
         cdb_row.branch_mispredict = head.mispredict;
         cdb_row.branch_target     = head.target;
      end
   end

   // Predictor training pulse in the grant cycle
   always_comb begin
      bp_upd_valid  = pop;
      bp_upd_pc     = '0;
      bp_upd_taken  = 1'b0;
      bp_upd_target = '0;
      if (pop) begin
         bp_upd_pc     = head.pc;
         bp_upd_taken  = head.taken;
         bp_upd_target = head.target;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   // Saturating counters of granted results and granted mispredicts
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else if (pop) begin
         if (stat_resolved != '1) stat_resolved <= stat_resolved + 32'd1;
         if (head.mispredict && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;
   import branch_resolve_pkg::*;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            issue_valid = 1'b0;
   BR_ISSUE         issue_pkt;
   logic            issue_ready;
   logic            flush = 1'b0;
   logic            cdb_req;
   logic            cdb_grant = 1'b0;
   CDB_ROW          cdb_row;
   logic            bp_upd_valid;
   logic [XLEN-1:0] bp_upd_pc;
   logic            bp_upd_taken;
   logic [XLEN-1:0] bp_upd_target;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0]     stat_resolved, stat_mispred;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int exp_res = 0;
   int exp_mis = 0;

   branch_resolve dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_pkt     (issue_pkt),
      .issue_ready   (issue_ready),
      .flush         (flush),
      .cdb_req       (cdb_req),
      .cdb_grant     (cdb_grant),
      .cdb_row       (cdb_row),
      .bp_upd_valid  (bp_upd_valid),
      .bp_upd_pc     (bp_upd_pc),
      .bp_upd_taken  (bp_upd_taken),
      .bp_upd_target (bp_upd_target)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_resolved (stat_resolved),
      .stat_mispred  (stat_mispred)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input BR_FUNC f, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                        input logic [31:0] ptg, input logic [5:0] rob);
      issue_pkt             = '0;
      issue_pkt.func        = f;
      issue_pkt.pc          = pc;
      issue_pkt.rs1_val     = rs1;
      issue_pkt.rs2_val     = rs2;
      issue_pkt.imm         = imm;
      issue_pkt.pred_taken  = pt;
      issue_pkt.pred_target = ptg;
      issue_pkt.rob_id      = rob;
      issue_pkt.phys_reg    = 7'(rob) + 7'd40;
      issue_valid           = 1'b1;
   endtask

   typedef struct {
      BR_FUNC      f;
      logic [31:0] pc, rs1, rs2, imm;
      logic        pt;
      logic [31:0] ptg;
      logic        tk, mis;
      logic [31:0] tgt;
   } vec_t;

   vec_t vecs [8];

   initial begin
      issue_pkt = '0;
      vecs[0] = '{BR_BEQ,  32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 1'b1, 1'b0, 32'h120};
      vecs[1] = '{BR_BNE,  32'h400, 32'd3, 32'd3, 32'h10, 1'b1, 32'h410, 1'b0, 1'b1, 32'h404};
      vecs[2] = '{BR_BGE,  32'h500, 32'hffffffff, 32'd1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h504};
      vecs[3] = '{BR_BLTU, 32'h600, 32'd1, 32'hffffffff, 32'h100, 1'b1, 32'h700, 1'b1, 1'b0, 32'h700};
      vecs[4] = '{BR_BGEU, 32'h700, 32'hffffffff, 32'd1, 32'hfffffff0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6f0};
      vecs[5] = '{BR_JAL,  32'h800, 32'd0, 32'd0, 32'h80, 1'b1, 32'h880, 1'b1, 1'b0, 32'h880};
      vecs[6] = '{BR_JALR, 32'h300, 32'h1003, 32'd0, 32'h0, 1'b1, 32'h1002, 1'b1, 1'b0, 32'h1002};
      vecs[7] = '{BR_BEQ,  32'hfffffffc, 32'd7, 32'd7, 32'h8, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4};

      // held in reset
      tick(); tick();
      chk("rst_cdb_req", 64'(cdb_req), 64'd0);
      chk("rst_cdb_row", 64'(cdb_row), 64'd0);
      chk("rst_bp_valid", 64'(bp_upd_valid), 64'd0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      reset = 1'b1;
      tick();
      chk("post_rst_ready", 64'(issue_ready), 64'd1);

      // BEQ correct predict with grant held high
      cdb_grant = 1'b1;
      drive(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 6'd1);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("beq_valid", 64'(cdb_row.valid), 64'd1);
      chk("beq_mis", 64'(cdb_row.branch_mispredict), 64'd0);
      chk("beq_tgt", 64'(cdb_row.branch_target), 64'h120);
      chk("beq_bp_valid", 64'(bp_upd_valid), 64'd1);
      chk("beq_bp_taken", 64'(bp_upd_taken), 64'd1);
      chk("beq_bp_pc", 64'(bp_upd_pc), 64'h100);
      exp_res++;
      tick();
      cdb_grant = 1'b0;
      #1;
      chk("beq_drained", 64'(cdb_req), 64'd0);

      // BLT mispredict: issue blocked until the entry is granted
      drive(BR_BLT, 32'h200, 32'hffffffff, 32'd1, 32'h40, 1'b0, 32'h0, 6'd2);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("blt_mis", 64'(cdb_row.branch_mispredict), 64'd1);
      chk("blt_tgt", 64'(cdb_row.branch_target), 64'h240);
      chk("blt_hold_ready", 64'(issue_ready), 64'd0);
      tick();
      chk("blt_hold_ready2", 64'(issue_ready), 64'd0);
      cdb_grant = 1'b1;
      #1;
      chk("blt_bp_valid", 64'(bp_upd_valid), 64'd1);
      chk("blt_bp_tgt", 64'(bp_upd_target), 64'h240);
      chk("blt_grant_ready", 64'(issue_ready), 64'd0);
      exp_res++; exp_mis++;
      tick();
      cdb_grant = 1'b0;
      #1;
      chk("blt_run_ready", 64'(issue_ready), 64'd1);
      chk("blt_drained", 64'(cdb_req), 64'd0);

      // function table
      foreach (vecs[i]) begin
         drive(vecs[i].f, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
               vecs[i].pt, vecs[i].ptg, 6'(i + 8));
         tick();
         issue_valid = 1'b0;
         #1;
         chk($sformatf("v%0d_valid", i), 64'(cdb_row.valid), 64'd1);
         chk($sformatf("v%0d_mis", i), 64'(cdb_row.branch_mispredict), 64'(vecs[i].mis));
         chk($sformatf("v%0d_tgt", i), 64'(cdb_row.branch_target), 64'(vecs[i].tgt));
         chk($sformatf("v%0d_rob", i), 64'(cdb_row.rob_id), 64'(i + 8));
         cdb_grant = 1'b1;
         #1;
         chk($sformatf("v%0d_bp_taken", i), 64'(bp_upd_taken), 64'(vecs[i].tk));
         chk($sformatf("v%0d_bp_pc", i), 64'(bp_upd_pc), 64'(vecs[i].pc));
         exp_res++;
         if (vecs[i].mis) exp_mis++;
         tick();
         cdb_grant = 1'b0;
         #1;
         chk($sformatf("v%0d_ready", i), 64'(issue_ready), 64'd1);
      end

      // fill with grant low: third packet must be refused
      for (int i = 0; i < 3; i++) begin
         drive(BR_JAL, 32'h10 * (i + 1), 32'd0, 32'd0, 32'h40, 1'b1, 32'h10 * (i + 1) + 32'h40, 6'(20 + i));
         #1;
         chk($sformatf("fill%0d_ready", i), 64'(issue_ready), (i < 2) ? 64'd1 : 64'd0);
         tick();
      end
      issue_valid = 1'b0;
      #1;
      chk("full_req", 64'(cdb_req), 64'd1);
      cdb_grant = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("drain%0d_rob", i), 64'(cdb_row.rob_id), 64'(20 + i));
         chk($sformatf("drain%0d_tgt", i), 64'(cdb_row.branch_target), 64'(32'h10 * (i + 1) + 32'h40));
         exp_res++;
         tick();
      end
      cdb_grant = 1'b0;
      #1;
      chk("drain_empty", 64'(cdb_req), 64'd0);

      // flush with two queued and grant high
      for (int i = 0; i < 2; i++) begin
         drive(BR_JAL, 32'h900, 32'd0, 32'd0, 32'h4, 1'b1, 32'h904, 6'(30 + i));
         tick();
      end
      issue_valid = 1'b0;
      flush = 1'b1;
      cdb_grant = 1'b1;
      #1;
      chk("flush_bp_valid", 64'(bp_upd_valid), 64'd0);
      chk("flush_ready", 64'(issue_ready), 64'd0);
      tick();
      flush = 1'b0;
      cdb_grant = 1'b0;
      #1;
      chk("flush_req", 64'(cdb_req), 64'd0);
      chk("flush_row", 64'(cdb_row), 64'd0);
      chk("flush_ready_after", 64'(issue_ready), 64'd1);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("stat_res", 64'(stat_resolved), 64'(exp_res));
      chk("stat_mis", 64'(stat_mispred), 64'(exp_mis));
`endif

      // asynchronous reset with entries queued
      for (int i = 0; i < 2; i++) begin
         drive(BR_BEQ, 32'ha00, 32'd1, 32'd1, 32'h8, 1'b1, 32'ha08, 6'(40 + i));
         tick();
      end
      issue_valid = 1'b0;
      cdb_grant = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_req", 64'(cdb_req), 64'd0);
      chk("arst_row", 64'(cdb_row), 64'd0);
      chk("arst_bp_valid", 64'(bp_upd_valid), 64'd0);
      chk("arst_ready", 64'(issue_ready), 64'd0);
      cdb_grant = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("arst_release_ready", 64'(issue_ready), 64'd1);
      chk("arst_release_req", 64'(cdb_req), 64'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("arst_stat_res", 64'(stat_resolved), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have: issue_valid  in  1  branch packet offered this cycle.
REQ-004 SHALL have: issue_pkt  in  BR_ISSUE  pc, rs1_val, rs2_val, imm (XLEN each), func (BR_FUNC), pred_taken, pred_target, rob_id, phys_reg.
REQ-005 SHALL have: issue_ready  out  1  packet accepted when issue_valid && issue_ready at rising edge.
REQ-006 SHALL have: flush  in  1  squash all held state.
REQ-007 SHALL have: cdb_req  out  1  request for a CDB lane.
REQ-008 SHALL have: cdb_grant  in  1  arbiter accepts cdb_row this cycle.
REQ-009 SHALL have: cdb_row  out  CDB_ROW  valid, rob_id, phys_reg, branch_mispredict, branch_target.
REQ-010 SHALL have: bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target  out  1/XLEN/1/XLEN  predictor training.

Function
REQ-011 SHALL evaluate func: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned), JAL (taken, pc+imm), JALR (taken, (rs1+imm)&~1).
REQ-012 SHALL compute actual_next = taken ? target : pc+4; pred_next = pred_taken ? pred_target : pc+4; all adds modulo 2^XLEN.
REQ-013 SHALL set branch_mispredict = (actual_next != pred_next); branch_target = actual_next.
REQ-014 SHALL write an accepted packet's result into a 2-entry FIFO at the accepting edge; cdb_req asserts the next cycle (latency 1).
REQ-015 SHALL drive cdb_req = FIFO non-empty; cdb_row = head entry with valid = cdb_req; cdb_row all-zero when empty.
REQ-016 SHALL pop head on cdb_grant && cdb_req; simultaneous push and pop allowed when FIFO full-then-pop is not required (issue_ready depends only on registered state).
REQ-017 SHALL drive issue_ready = !full && state==RUN && !flush.
REQ-018 SHALL implement FSM RUN/HOLD: RUN->HOLD when a mispredicted result is pushed; HOLD->RUN when that entry is granted; no issue accepted in HOLD (wrong-path block).
REQ-019 SHALL pulse bp_upd_* for exactly one cycle, same cycle as grant, carrying head pc/taken/target.
REQ-020 SHALL, on flush, clear FIFO and return to RUN at that edge; flush overrides same-cycle issue and grant (no pop, no bp_upd pulse).
REQ-021 SHALL ignore cdb_grant when cdb_req is 0.
REQ-022 SHALL wrap FIFO pointers modulo 2 with a 2-bit count (0..2).

Reset
REQ-023 SHALL, while reset=0, hold FIFO empty, state RUN, cdb_req=0, cdb_row=0, bp_upd_valid=0, issue_ready=0.
REQ-024 SHALL assert issue_ready in the first cycle after reset deasserts; reset mid-operation discards all entries without any grant-side output.

Configuration
REQ-025 SHALL, with BRANCH_RESOLVE_STATS_EN defined, provide outputs stat_resolved and stat_mispred (32 bits each, reset 0, saturating) counting granted entries and granted mispredicts; flushed entries not counted.
REQ-026 SHALL, without BRANCH_RESOLVE_STATS_EN, omit those ports and counters entirely.

Structure
REQ-027 SHALL take CDB_ROW, BR_FUNC, BR_ISSUE, XLEN from the shared package; FIFO depth is a local constant.
REQ-028 SHALL place condition/target evaluation in combinational sub-module br_cond_eval.

Verification
REQ-029 BEQ pc=0x100, rs1=rs2=5, imm=0x20, pred_taken=1, pred_target=0x120, grant held 1 -> next cycle cdb_row valid, mispredict=0, target=0x120, bp_upd_taken=1.
REQ-030 BLT rs1=-1, rs2=1, pc=0x200, pred_taken=0 -> mispredict=1, target=pc+imm; issue_ready=0 until grant, then 1.
REQ-031 JALR rs1=0x1003, imm=0, pred_target=0x1002 -> target=0x1002, mispredict=0.
REQ-032 Grant held 0, issue 3 correct-predict packets -> issue_ready=0 after 2 accepts; raise grant -> rows emerge in order, one per cycle.
REQ-033 Two entries queued, flush asserted with grant -> FIFO empty next cycle, no bp_upd pulse, stats unchanged.
REQ-034 Reset asserted (0) with entries queued -> cdb_req=0 and cdb_row=0 immediately, issue_ready=1 the first cycle after release.
